// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle for the byte_word_packer.
// master drives bytes and consumes words; slave is the packer.
interface byte_word_packer_if #(
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [3:0]    out_keep;
  logic          out_last;
  logic          out_ready;
  logic [LW-1:0] fifo_level;
  logic [31:0]   byte_count;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_keep,
    input  out_last,
    input  fifo_level,
    input  byte_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_keep,
    output out_last,
    output fifo_level,
    output byte_count
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words with keep/last and
// buffers them in a first-word-fall-through FIFO.
module byte_word_packer #(
  parameter int DEPTH         = 4,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  byte_word_packer_if.slave io_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [1:0]    r_lane;
  logic [31:0]   r_asm;
  logic [31:0]   r_data [DEPTH];
  logic [3:0]    r_keep [DEPTH];
  logic          r_last [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [31:0]   r_count;
  logic          r_ready;

  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_word;
  logic [3:0]    w_keep;
  logic [LW-1:0] w_level_nxt;
  logic [4:0]    w_bit;

  assign w_acc  = io_bus.in_valid & r_ready;
  assign w_push = w_acc &
                  ((r_lane == 2'd3) | io_bus.in_last);
  assign w_pop  = (r_level != '0) & io_bus.out_ready;

  // Lane 0 is always the first byte; endianness only moves it
  always_comb begin
    if (LITTLE_ENDIAN)
      w_bit = {r_lane, 3'b000};
    else
      w_bit = {~r_lane, 3'b000};
  end

  always_comb begin
    w_word = r_asm;
    w_word[w_bit +: 8] = io_bus.in_data;
  end

  always_comb begin
    w_keep = 4'b0001;
    case (r_lane)
      2'd0: w_keep = 4'b0001;
      2'd1: w_keep = 4'b0011;
      2'd2: w_keep = 4'b0111;
      2'd3: w_keep = 4'b1111;
      default: w_keep = 4'b0001;
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane  <= '0;
      r_asm   <= '0;
      r_count <= '0;
    end else if (w_acc) begin
      r_count <= r_count + 32'd1;
      if (w_push) begin
        r_lane <= '0;
        r_asm  <= '0;
      end else begin
        r_lane <= r_lane + 2'd1;
        r_asm  <= w_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_keep[i] <= '0;
        r_last[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_data[r_wptr] <= w_word;
      r_keep[r_wptr] <= w_keep;
      r_last[r_wptr] <= io_bus.in_last;
    end
  end

  // Ready is precomputed from next level: no out_ready path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != FULL);
    end
  end

  assign io_bus.in_ready   = r_ready;
  assign io_bus.out_valid  = (r_level != '0);
  assign io_bus.out_data   = r_data[r_rptr];
  assign io_bus.out_keep   = r_keep[r_rptr];
  assign io_bus.out_last   = r_last[r_rptr];
  assign io_bus.fifo_level = r_level;
  assign io_bus.byte_count = r_count;
endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: little-endian DUT with
// a word queue, plus a big-endian instance for lane ordering.
module tb_byte_word_packer;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   pops;
  exp_t q[$];
  logic [1:0]  m_lane;
  logic [31:0] m_asm;

  byte_word_packer_if #(.DEPTH(4)) ia ();
  byte_word_packer_if #(.DEPTH(4)) ib ();

  byte_word_packer #(
    .DEPTH(4),
    .LITTLE_ENDIAN(1'b1)
  ) dut_a (
    .clk(clk),
    .rst_n(rst_n),
    .io_bus(ia)
  );

  byte_word_packer #(
    .DEPTH(4),
    .LITTLE_ENDIAN(1'b0)
  ) dut_b (
    .clk(clk),
    .rst_n(rst_n),
    .io_bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ia.out_valid && ia.out_ready) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL sb_extra: got word %h expected none",
               ia.out_data);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_data", ia.out_data, e.d);
        check("sb_keep", 32'(ia.out_keep), 32'(e.k));
        check("sb_last", 32'(ia.out_last), 32'(e.l));
        pops++;
      end
    end
  end

  task automatic model_accept(logic [7:0] b, logic last);
    exp_t e;
    m_asm[8*m_lane +: 8] = b;
    if (m_lane == 2'd3 || last) begin
      e.d = m_asm;
      e.k = 4'((5'd1 << (m_lane + 3'd1)) - 5'd1);
      e.l = last;
      q.push_back(e);
      m_lane = 2'd0;
      m_asm  = '0;
    end else begin
      m_lane = m_lane + 2'd1;
    end
  endtask

  task automatic send(logic [7:0] b, logic last);
    int n;
    bit done;
    n = 0;
    done = 0;
    ia.in_valid = 1'b1;
    ia.in_data  = b;
    ia.in_last  = last;
    while (!done) begin
      @(negedge clk);
      if (ia.in_ready)
        done = 1;
      else if (++n > 200) begin
        errors++;
        $display("FAIL send_timeout: got no in_ready expected ready");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "send timeout");
      end
      @(posedge clk);
      #1;
    end
    model_accept(b, last);
  endtask

  task automatic idle();
    ia.in_valid = 1'b0;
    ia.in_last  = 1'b0;
  endtask

  task automatic do_reset(string tag);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    #3;
    check({tag, "_in_ready"}, ia.in_ready, 0);
    check({tag, "_out_valid"}, ia.out_valid, 0);
    check({tag, "_level"}, 32'(ia.fifo_level), 0);
    check({tag, "_count"}, ia.byte_count, 0);
    q.delete();
    m_lane = '0;
    m_asm  = '0;
    pops   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ready_rel"}, ia.in_ready, 1);
  endtask

  task automatic drain(string tag, int exp_pops);
    int n;
    n = 0;
    ia.out_ready = 1'b1;
    while ((q.size() != 0 || ia.out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_q_empty"}, q.size(), 0);
    check({tag, "_level0"}, 32'(ia.fifo_level), 0);
    check({tag, "_pops"}, pops, exp_pops);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pops   = 0;
    m_lane = '0;
    m_asm  = '0;
    rst_n  = 1'b0;
    ia.in_valid  = 1'b0;
    ia.in_data   = '0;
    ia.in_last   = 1'b0;
    ia.out_ready = 1'b0;
    ib.in_valid  = 1'b0;
    ib.in_data   = '0;
    ib.in_last   = 1'b0;
    ib.out_ready = 1'b1;

    #3;
    check("rst_in_ready", ia.in_ready, 0);
    check("rst_out_valid", ia.out_valid, 0);
    check("rst_out_data", ia.out_data, 0);
    check("rst_out_keep", 32'(ia.out_keep), 0);
    check("rst_out_last", 32'(ia.out_last), 0);
    check("rst_level", 32'(ia.fifo_level), 0);
    check("rst_count", ia.byte_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", ia.in_ready, 1);

    // full word, little-endian
    ia.out_ready = 1'b1;
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    idle();
    check("w1_valid", ia.out_valid, 1);
    check("w1_data", ia.out_data, 32'h44332211);
    check("w1_keep", 32'(ia.out_keep), 32'hF);
    check("w1_last", 32'(ia.out_last), 0);
    check("w1_count", ia.byte_count, 4);

    // partial flush, then next byte in lane 0
    send(8'hAA, 0);
    send(8'hBB, 1);
    idle();
    check("p_data", ia.out_data, 32'h0000BBAA);
    check("p_keep", 32'(ia.out_keep), 32'h3);
    check("p_last", 32'(ia.out_last), 1);
    send(8'h01, 1);
    idle();
    check("l0_data", ia.out_data, 32'h00000001);
    check("l0_keep", 32'(ia.out_keep), 32'h1);
    drain("t12", 3);

    // backpressure: 20 bytes into a 4-word FIFO
    do_reset("r1");
    ia.out_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      send(8'(8'h40 + i), 0);
    check("bp_level", 32'(ia.fifo_level), 4);
    check("bp_ready", ia.in_ready, 0);
    ia.in_valid = 1'b1;
    ia.in_data  = 8'h50;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("bp_stall_count", ia.byte_count, 16);
    check("bp_stall_level", 32'(ia.fifo_level), 4);
    ia.out_ready = 1'b1;
    for (int i = 16; i < 20; i++)
      send(8'(8'h40 + i), 0);
    idle();
    drain("bp", 5);
    check("bp_count", ia.byte_count, 20);

    // simultaneous push and pop at level 3
    do_reset("r2");
    ia.out_ready = 1'b0;
    for (int i = 0; i < 15; i++)
      send(8'(8'h80 + i), 0);
    check("pp_level_pre", 32'(ia.fifo_level), 3);
    ia.out_ready = 1'b1;
    send(8'h8F, 0);
    ia.out_ready = 1'b0;
    idle();
    check("pp_level", 32'(ia.fifo_level), 3);
    check("pp_head", ia.out_data, 32'h87868584);
    drain("pp", 4);

    // reset mid-word discards partial bytes
    ia.out_ready = 1'b1;
    send(8'h01, 0);
    send(8'h02, 0);
    idle();
    do_reset("r3");
    ia.out_ready = 1'b1;
    send(8'hA0, 0);
    send(8'hA1, 0);
    send(8'hA2, 0);
    send(8'hA3, 0);
    idle();
    check("mr_data", ia.out_data, 32'hA3A2A1A0);
    check("mr_keep", 32'(ia.out_keep), 32'hF);
    drain("mr", 1);

    // big-endian lane placement
    for (int i = 0; i < 4; i++) begin
      ib.in_valid = 1'b1;
      ib.in_data  = 8'(8'h11 * (i + 1));
      @(posedge clk);
      #1;
    end
    ib.in_valid = 1'b0;
    check("be_valid", ib.out_valid, 1);
    check("be_data", ib.out_data, 32'h11223344);
    check("be_keep", 32'(ib.out_keep), 32'hF);
    check("be_count", ib.byte_count, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Downstream consumer of the 8-bit register stage output. It packs the incoming byte stream into 32-bit words and buffers the completed words in a small FIFO.
- Completed words are presented on a valid/ready interface to the next 32-bit stage, such as a memory write port or a bus bridge.
- Partial words can be flushed with a last marker; byte lanes are qualified by keep bits.

Parameters:
- DEPTH, 4, number of 32-bit word entries in the output FIFO; power of 2, at least 2.
- LITTLE_ENDIAN, 1. When 1, the first byte goes to out_data[7:0]. When 0, the first byte goes to out_data[31:24].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data and in_last are valid this cycle.
- in_data  input  8  byte from the upstream register stage.
- in_last  input  1  this byte ends a packet; flush the partial word.
- in_ready  output  1  the packer accepts a byte this cycle.
- out_valid  output  1  the FIFO head word is valid.
- out_data  output  32  packed word.
- out_keep  output  4  bit i is set when byte lane i holds a real byte; lane 0 is the first byte.
- out_last  output  1  the word ends a packet.
- out_ready  input  1  the downstream stage takes the head word.
- fifo_level  output  $clog2(DEPTH)+1  number of stored words.
- byte_count  output  32  total bytes accepted since reset; wraps modulo 2^32.

Behaviour:
- Reset is asynchronous on rst_n low; release is synchronous. While in reset, and on the first edge after release:
  - in_ready=0 during reset, then 1 after release.
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - fifo_level=0, byte_count=0.
  - lane index=0, assembly register=0.
- Accept condition: a byte is accepted when in_valid && in_ready. Only accepted bytes change state.
- in_ready = (fifo_level != DEPTH). It is registered-state based, with no combinational path from out_ready. When the FIFO is full, in_ready=0 even if a pop occurs that cycle.
- Assembler:
  - A 2-bit lane index selects the byte position. The accepted byte is written into that lane of the assembly register, and the index then increments.
  - A word is pushed into the FIFO when the accepted byte lands in lane 3, or when in_last=1. The lane index then returns to 0 and the assembly register clears.
  - keep on push = lanes 0..k all set, where k is the lane of the final byte. Examples: k=0 gives 4'b0001, k=3 gives 4'b1111.
  - Unused lanes are 0. last on push = in_last.
  - in_last on lane 3 gives a single full word with last=1.
- Push can never fail, because acceptance requires a free slot.
- FIFO:
  - First-word-fall-through circular buffer with read and write pointers.
  - out_valid = (fifo_level != 0). out_data, out_keep and out_last show the head entry.
  - Pop occurs when out_valid && out_ready.
  - Head outputs stay stable while out_valid && !out_ready.
- Latency: the word completed by the byte accepted at edge N is visible on out_valid after edge N, i.e. in cycle N+1, when the FIFO was empty.
- fifo_level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Pointers wrap modulo DEPTH.
- byte_count increments by 1 per accepted byte. It wraps 0xFFFFFFFF to 0.
- When in_valid=0 the assembler holds indefinitely; there is no timeout flush.
- Reset mid-operation discards the partial word and all FIFO contents; nothing is emitted for them.

Test Plan:
- Reset, LITTLE_ENDIAN=1, out_ready=1. Feed 0x11,0x22,0x33,0x44 back to back with in_last=0 -> one cycle after the 4th byte: out_valid=1, out_data=0x44332211, out_keep=4'hF, out_last=0. byte_count=4.
- Feed 0xAA then 0xBB with in_last=1 -> out_data=0x0000BBAA, out_keep=4'h3, out_last=1. The next byte lands in lane 0.
- out_ready=0, DEPTH=4, stream 20 bytes -> in_ready drops after byte 16 and fifo_level=4. Bytes 17–20 stall. Raise out_ready -> 5 words come out in order with no loss or duplication, and byte_count=20.
- LITTLE_ENDIAN=0, feed 0x11,0x22,0x33,0x44 -> out_data=0x11223344, out_keep=4'hF.
- Accept 0x01,0x02, then pulse rst_n low mid-word -> out_valid=0, fifo_level=0, byte_count=0. Then feed 0xA0..0xA3 -> a single word 0xA3A2A1A0; no residue from 0x01/0x02.
- With fifo_level=3, push and pop in the same cycle -> fifo_level stays 3, and head order is preserved.
